// File: rtl/axil_dp_ram_if.sv
// AXI4-Lite bundle for the dual-port RAM: read-only port A plus read/write port B.
interface axil_dp_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] a_araddr;
  logic                  a_arvalid;
  logic                  a_arready;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [1:0]            a_rresp;
  logic                  a_rvalid;
  logic                  a_rready;

  logic [ADDR_WIDTH-1:0] b_awaddr;
  logic                  b_awvalid;
  logic                  b_awready;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [NBYTES-1:0]     b_wstrb;
  logic                  b_wvalid;
  logic                  b_wready;
  logic [1:0]            b_bresp;
  logic                  b_bvalid;
  logic                  b_bready;
  logic [ADDR_WIDTH-1:0] b_araddr;
  logic                  b_arvalid;
  logic                  b_arready;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic [1:0]            b_rresp;
  logic                  b_rvalid;
  logic                  b_rready;

  modport master (
    output a_araddr, a_arvalid, a_rready,
    input  a_arready, a_rdata, a_rresp, a_rvalid,
    output b_awaddr, b_awvalid, b_wdata, b_wstrb, b_wvalid, b_bready,
    output b_araddr, b_arvalid, b_rready,
    input  b_awready, b_wready, b_bresp, b_bvalid,
    input  b_arready, b_rdata, b_rresp, b_rvalid
  );

  modport slave (
    input  a_araddr, a_arvalid, a_rready,
    output a_arready, a_rdata, a_rresp, a_rvalid,
    input  b_awaddr, b_awvalid, b_wdata, b_wstrb, b_wvalid, b_bready,
    input  b_araddr, b_arvalid, b_rready,
    output b_awready, b_wready, b_bresp, b_bvalid,
    output b_arready, b_rdata, b_rresp, b_rvalid
  );
endinterface

// File: rtl/axil_dp_ram.sv
// Dual-port AXI4-Lite on-chip RAM: port A read-only fetch, port B read/write data.
// Read-first collisions, independent AW/W acceptance, SLVERR outside the address window.
module axil_dp_ram #(
  parameter int unsigned          MEM_SIZE_BYTES = 8192,
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic          clk,
  input  logic          rst,
  axil_dp_ram_if.slave  bus
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(NBYTES);
  localparam int unsigned DEPTH  = MEM_SIZE_BYTES / NBYTES;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state, state_next;
  logic                  commit_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NBYTES-1:0]     wr_strb_c;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NBYTES-1:0]     strb_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off < ADDR_WIDTH'(MEM_SIZE_BYTES);
  endfunction

  // Window is aligned to its size, so the word index is a plain address slice.
  assign bus.a_arready = !bus.a_rvalid || bus.a_rready;
  assign bus.b_arready = !bus.b_rvalid || bus.b_rready;

  // Port A read channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.a_rresp  <= RESP_OKAY;
    end else if (bus.a_arvalid && bus.a_arready) begin
      bus.a_rvalid <= 1'b1;
      if (in_range(bus.a_araddr)) begin
        bus.a_rdata <= mem[bus.a_araddr[LSB +: IDX_W]];
        bus.a_rresp <= RESP_OKAY;
      end else begin
        bus.a_rdata <= '0;
        bus.a_rresp <= RESP_SLVERR;
      end
    end else if (bus.a_rready) begin
      bus.a_rvalid <= 1'b0;
    end
  end

  // Port B read channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.b_rvalid <= 1'b0;
      bus.b_rdata  <= '0;
      bus.b_rresp  <= RESP_OKAY;
    end else if (bus.b_arvalid && bus.b_arready) begin
      bus.b_rvalid <= 1'b1;
      if (in_range(bus.b_araddr)) begin
        bus.b_rdata <= mem[bus.b_araddr[LSB +: IDX_W]];
        bus.b_rresp <= RESP_OKAY;
      end else begin
        bus.b_rdata <= '0;
        bus.b_rresp <= RESP_SLVERR;
      end
    end else if (bus.b_rready) begin
      bus.b_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= W_IDLE;
    else     state <= state_next;
  end

  // Write FSM: commit selects whichever half was held and whichever is live
  always_comb begin
    state_next    = state;
    commit_c      = 1'b0;
    bus.b_awready = 1'b0;
    bus.b_wready  = 1'b0;
    wr_addr_c     = bus.b_awaddr;
    wr_data_c     = bus.b_wdata;
    wr_strb_c     = bus.b_wstrb;
    case (state)
      W_IDLE: begin
        bus.b_awready = 1'b1;
        bus.b_wready  = 1'b1;
        if (bus.b_awvalid && bus.b_wvalid) begin
          commit_c   = 1'b1;
          state_next = W_RESP;
        end else if (bus.b_awvalid) begin
          state_next = W_ADDR;
        end else if (bus.b_wvalid) begin
          state_next = W_DATA;
        end
      end
      W_ADDR: begin
        bus.b_wready = 1'b1;
        wr_addr_c    = addr_q;
        if (bus.b_wvalid) begin
          commit_c   = 1'b1;
          state_next = W_RESP;
        end
      end
      W_DATA: begin
        bus.b_awready = 1'b1;
        wr_data_c     = data_q;
        wr_strb_c     = strb_q;
        if (bus.b_awvalid) begin
          commit_c   = 1'b1;
          state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.b_bready) state_next = W_IDLE;
      end
      default: state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.b_bvalid <= 1'b0;
      bus.b_bresp  <= RESP_OKAY;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
    end else begin
      if (commit_c) begin
        bus.b_bvalid <= 1'b1;
        bus.b_bresp  <= in_range(wr_addr_c) ? RESP_OKAY : RESP_SLVERR;
      end else if (bus.b_bvalid && bus.b_bready) begin
        bus.b_bvalid <= 1'b0;
      end
      if (state == W_IDLE && bus.b_awvalid && !bus.b_wvalid) addr_q <= bus.b_awaddr;
      if (state == W_IDLE && bus.b_wvalid && !bus.b_awvalid) begin
        data_q <= bus.b_wdata;
        strb_q <= bus.b_wstrb;
      end
    end
  end

  // Array has no reset; writes are suppressed while rst is held
  always_ff @(posedge clk) begin
    if (commit_c && !rst && in_range(wr_addr_c)) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wr_strb_c[i]) mem[wr_addr_c[LSB +: IDX_W]][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end
endmodule
